// File: rtl/opamp_trim_cal.sv
// SAR offset-trim sequencer for a bank of NCH opamps sharing one comparator.
// Define OPAMP_TRIM_MAJ3_EN for a 3-sample majority-vote bit decision.
module opamp_trim_cal #(
    parameter int NCH        = 4,
    parameter int TRIM_W     = 6,
    parameter int SETTLE_CYC = 16,
    localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cmp_in,
    output logic                  busy,
    output logic                  done,
    output logic                  cal_en,
    output logic [CH_W-1:0]       ch_sel,
    output logic [NCH*TRIM_W-1:0] trim_out,
    output logic [NCH-1:0]        err
);
    localparam int CNT_W = $clog2(SETTLE_CYC);
    localparam int BIT_W = $clog2(TRIM_W);
    localparam logic [TRIM_W-1:0] MID = {1'b1, {(TRIM_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, NEXT_CH, DONE} state_t;

    state_t                     state;
    logic [NCH-1:0][TRIM_W-1:0] lanes;
    logic [CNT_W-1:0]           cnt;
    logic [BIT_W-1:0]           bit_idx;
    logic [CH_W-1:0]            ch;
    logic [CH_W-1:0]            ch_nx;
    logic                       cmp_m, cmp_s;
    logic                       samp_last, dec;

    assign ch_nx    = ch + 1'b1;
    assign ch_sel   = ch;
    assign trim_out = lanes;

`ifdef OPAMP_TRIM_MAJ3_EN
    // votes counts ones among the first two samples; the third completes the vote
    logic [1:0] votes, vsum;
    assign vsum      = votes + {1'b0, cmp_s};
    assign samp_last = (cnt == CNT_W'(2));
    assign dec       = vsum[1];
`else
    assign samp_last = 1'b1;
    assign dec       = cmp_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            cal_en  <= 1'b0;
            ch      <= '0;
            err     <= '0;
            cnt     <= '0;
            bit_idx <= '0;
            cmp_m   <= 1'b0;
            cmp_s   <= 1'b0;
            for (int k = 0; k < NCH; k++) lanes[k] <= MID;
`ifdef OPAMP_TRIM_MAJ3_EN
            votes   <= '0;
`endif
        end else begin
            cmp_m <= cmp_in;
            cmp_s <= cmp_m;
            done  <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    ch       <= '0;
                    bit_idx  <= BIT_W'(TRIM_W-1);
                    lanes[0] <= MID;
                    err      <= '0;
                    busy     <= 1'b1;
                    cal_en   <= 1'b1;
                    cnt      <= '0;
                    state    <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == CNT_W'(SETTLE_CYC-1)) begin
                        cnt   <= '0;
                        state <= SAMPLE;
`ifdef OPAMP_TRIM_MAJ3_EN
                        votes <= '0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    if (samp_last) begin
                        if (!dec) lanes[ch][bit_idx] <= 1'b0;
                        if (bit_idx != '0) begin
                            lanes[ch][bit_idx-1'b1] <= 1'b1;
                            bit_idx <= bit_idx - 1'b1;
                            cnt     <= '0;
                            state   <= SETTLE;
                        end else begin
                            state <= NEXT_CH;
                        end
                    end else begin
`ifdef OPAMP_TRIM_MAJ3_EN
                        votes <= vsum;
`endif
                        cnt <= cnt + 1'b1;
                    end
                end
                NEXT_CH: begin
                    // a code pinned at either rail means the trim range ran out
                    err[ch] <= (lanes[ch] == '0) || (lanes[ch] == '1);
                    if (ch != CH_W'(NCH-1)) begin
                        ch           <= ch_nx;
                        lanes[ch_nx] <= MID;
                        bit_idx      <= BIT_W'(TRIM_W-1);
                        cnt          <= '0;
                        state        <= SETTLE;
                    end else begin
                        busy   <= 1'b0;
                        cal_en <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_opamp_trim_cal.sv
// Randomized check of opamp_trim_cal against a spec-level SAR/timing model.
module tb_opamp_trim_cal;
    localparam int NCH = 4, TRIM_W = 6, SETTLE_CYC = 4;
`ifdef OPAMP_TRIM_MAJ3_EN
    localparam int PER_BIT = SETTLE_CYC + 3;
`else
    localparam int PER_BIT = SETTLE_CYC + 1;
`endif
    localparam int PER_CH = TRIM_W * PER_BIT + 1;
    localparam int LAT    = NCH * PER_CH + 1;
    localparam logic [TRIM_W-1:0] MID = 6'd32;
    localparam logic [TRIM_W-1:0] TOP = 6'd63;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, glitch = 1'b0;
    logic cmp_in, busy, done, cal_en;
    logic [1:0] ch_sel;
    logic [NCH*TRIM_W-1:0] trim_out;
    logic [NCH-1:0] err;
    logic [TRIM_W-1:0] tgt [NCH];
    logic [TRIM_W-1:0] prev [NCH];
    logic [TRIM_W-1:0] fin [NCH];
    int n_chk = 0, n_err = 0;

    opamp_trim_cal #(.NCH(NCH), .TRIM_W(TRIM_W), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clk(clk), .rst(rst), .start(start), .cmp_in(cmp_in), .busy(busy), .done(done),
        .cal_en(cal_en), .ch_sel(ch_sel), .trim_out(trim_out), .err(err)
    );

    always #5 clk = ~clk;

    // ideal comparator on the selected lane, optionally disturbed for one cycle
    assign cmp_in = (trim_out[ch_sel*TRIM_W +: TRIM_W] <= tgt[ch_sel]) ^ glitch;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [TRIM_W-1:0] lane(input int j);
        return trim_out[j*TRIM_W +: TRIM_W];
    endfunction

    function automatic logic [TRIM_W-1:0] sar_ref(input logic [TRIM_W-1:0] target);
        int code = 0;
        for (int b = TRIM_W-1; b >= 0; b--)
            if ((code | (1 << b)) <= int'(target)) code = code | (1 << b);
        return TRIM_W'(code);
    endfunction

    task automatic run_pass(input int glitch_k);
        int k, c, extra_k;
        logic [NCH-1:0] exp_err;
        logic [NCH*TRIM_W-1:0] exp_lanes;
        for (int j = 0; j < NCH; j++) begin
            fin[j] = sar_ref(tgt[j]);
            exp_err[j] = (fin[j] == '0) || (fin[j] == TOP);
            exp_lanes[j*TRIM_W +: TRIM_W] = fin[j];
        end
        extra_k = $urandom_range(1, NCH*PER_CH-1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!done && k < LAT + 20) begin
            c = k / PER_CH;
            if (k < NCH*PER_CH) begin
                chk("ch_sel", ch_sel, c);
                chk("busy", busy, 1);
                chk("cal_en", cal_en, 1);
                for (int j = 0; j < NCH; j++) begin
                    if (j < c) chk("lane_final", lane(j), fin[j]);
                    else if (j > c) chk("lane_hold", lane(j), prev[j]);
                end
            end else begin
                chk("busy_in_done", busy, 0);
            end
            // stray start requests: one mid-pass, one while in DONE
            start  = (k == extra_k) || (k == NCH*PER_CH);
            glitch = (k == glitch_k);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        glitch = 1'b0;
        chk("latency", k, LAT);
        chk("lanes", trim_out, exp_lanes);
        chk("err", err, exp_err);
        chk("busy_after", busy, 0);
        @(negedge clk);
        chk("done_pulse", done, 0);
        repeat (3) @(negedge clk);
        chk("no_restart", busy, 0);
        for (int j = 0; j < NCH; j++) prev[j] = fin[j];
    endtask

    function automatic int pick_glitch();
`ifdef OPAMP_TRIM_MAJ3_EN
        return $urandom_range(0, NCH*PER_CH-1);
`else
        return -1;
`endif
    endfunction

    initial begin
        for (int j = 0; j < NCH; j++) begin tgt[j] = MID; prev[j] = MID; end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_trim", trim_out, {NCH{MID}});
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cal_en", cal_en, 0);
        chk("rst_ch_sel", ch_sel, 0);
        rst = 1'b0;
        @(negedge clk);

        tgt[0] = 6'd37; tgt[1] = 6'd0; tgt[2] = 6'd63; tgt[3] = 6'd32;
`ifdef OPAMP_TRIM_MAJ3_EN
        run_pass(2*PER_BIT + SETTLE_CYC - 1);
`else
        run_pass(-1);
`endif

        for (int p = 0; p < 4; p++) begin
            for (int j = 0; j < NCH; j++) tgt[j] = TRIM_W'($urandom_range(0, 63));
            run_pass(pick_glitch());
        end

        for (int j = 0; j < NCH; j++) tgt[j] = TRIM_W'($urandom_range(0, 63));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (PER_CH + 2) @(negedge clk);
        chk("mid_ch_sel", ch_sel, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_trim", trim_out, {NCH{MID}});
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_cal_en", cal_en, 0);
        chk("mid_rst_ch_sel", ch_sel, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_idle", busy, 0);
        for (int j = 0; j < NCH; j++) prev[j] = MID;
        run_pass(pick_glitch());

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
